sd_multiblock_receiver: RTL

SPI-mode SD card receiver, next generation of the single-shot SD response receiver: captures R1/R1b/R2/R3/R7 responses and streams one or more data blocks of parametrised length. Data blocks are checked with CRC16 and delivered as a byte stream. Includes a start-bit timeout and an R1b busy wait. Sits between the SD SPI clock divider/shifter and the SD controller FSM.

---
 rtl/sd_multiblock_receiver_pkg.sv | 38 +++
 rtl/sd_crc16_serial.sv | 26 ++
 rtl/sd_multiblock_receiver.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sd_multiblock_receiver_pkg.sv
// Shared types and framing constants for the SPI-mode SD response/data receiver.
package sd_multiblock_receiver_pkg;

  typedef enum logic [2:0] {
    RxIdle,
    RxWaitStart,
    RxReceiving,
    RxCheckCrc,
    RxWaitBusy
  } sd_rx_fsm_t;

  typedef enum logic [2:0] {
    R1        = 3'd0,
    R1b       = 3'd1,
    R2        = 3'd2,
    R3OrR7    = 3'd3,
    DataBlock = 3'd4
  } sd_rx_kind_t;

  localparam int unsigned R1FrameBits   = 8;
  localparam int unsigned R2FrameBits   = 16;
  localparam int unsigned R3R7FrameBits = 40;
  localparam int unsigned TokenBits     = 8;
  localparam int unsigned CrcBits       = 16;

  localparam logic [7:0]  StartToken = 8'hFE;
  localparam logic [7:0]  IdleByte   = 8'hFF;
  localparam logic [15:0] Crc16Poly  = 16'h1021;

  function automatic logic [5:0] frame_bits(input sd_rx_kind_t kind);
    case (kind)
      R2:      return 6'(R2FrameBits);
      R3OrR7:  return 6'(R3R7FrameBits);
      default: return 6'(R1FrameBits);
    endcase
  endfunction

endpackage

// File: rtl/sd_crc16_serial.sv
// Bit-serial CRC16-CCITT (poly 0x1021), MSB first, zero initial value.
module sd_crc16_serial
  import sd_multiblock_receiver_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic w_feedback;
  assign w_feedback = crc[15] ^ bit_in;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[14:0], 1'b0} ^ (w_feedback ? Crc16Poly : 16'h0000);
    end
  end

endmodule

// File: rtl/sd_multiblock_receiver.sv
// SPI-mode SD receiver: R1/R1b/R2/R3/R7 responses and CRC16-checked multi-block data.
module sd_multiblock_receiver
  import sd_multiblock_receiver_pkg::*;
#(
  parameter int unsigned BlockBytes      = 512,
  parameter int unsigned BlockCountWidth = 16,
  parameter int unsigned TimeoutBits     = 65535
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       sample_en,
  input  logic                       miso,
  input  logic                       start,
  input  logic [2:0]                 response_type,
  input  logic [BlockCountWidth-1:0] block_count,
  input  logic                       stop,
  output logic                       busy,
  output logic [39:0]                response,
  output logic                       response_valid,
  output logic [7:0]                 data,
  output logic                       data_valid,
  output logic                       block_done,
  output logic                       crc_error,
  output logic                       token_error,
  output logic                       timeout,
  output logic                       done
);

  localparam int unsigned PayloadBits = BlockBytes * 8;
  localparam int unsigned FrameBits   = TokenBits + PayloadBits + CrcBits;
  localparam int unsigned CW          = $clog2(FrameBits + 1);
  localparam int unsigned TW          = $clog2(TimeoutBits + 1);

  localparam logic [CW-1:0] PayloadEnd  = CW'(TokenBits + PayloadBits);
  localparam logic [CW-1:0] FrameLast   = CW'(FrameBits - 1);
  localparam logic [TW-1:0] TimeoutLast = TW'(TimeoutBits - 1);

  sd_rx_fsm_t                 r_state;
  sd_rx_kind_t                r_kind;
  logic [BlockCountWidth-1:0] r_remaining;
  logic                       r_stop;
  logic [CW-1:0]              r_bitcnt;
  logic [TW-1:0]              r_tocnt;
  logic [2:0]                 r_phase;
  logic [39:0]                r_shift;

  logic [39:0] w_shift_next;
  logic [15:0] w_crc;
  logic        w_token_seen;
  logic        w_resp_last;
  logic        w_payload_bit;
  logic        w_crc_clear;
  logic        w_crc_bad;
  logic        w_to_count;

  assign busy         = (r_state != RxIdle);
  assign w_shift_next = {r_shift[38:0], miso};
  // Data tokens are byte-aligned: 0xFE has a leading 1, so the first 0 bit
  // cannot mark its start the way it does for responses.
  assign w_token_seen = (r_phase == 3'd7) && (w_shift_next[7:0] != IdleByte);
  assign w_resp_last  = (r_bitcnt == CW'(frame_bits(r_kind) - 6'd1));
  assign w_payload_bit = (r_state == RxReceiving) && (r_kind == DataBlock) &&
                         (r_bitcnt < PayloadEnd);
  assign w_crc_clear  = ((r_state == RxIdle) && start && !done) || (r_state == RxCheckCrc);
  assign w_crc_bad    = (w_crc != r_shift[15:0]);
  assign w_to_count   = sample_en &&
                        (((r_state == RxWaitStart) && miso &&
                          !((r_kind == DataBlock) && w_token_seen)) ||
                         ((r_state == RxWaitBusy) && !miso));

  sd_crc16_serial u_crc (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_crc_clear),
    .enable (sample_en && w_payload_bit),
    .bit_in (miso),
    .crc    (w_crc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= RxIdle;
      r_kind         <= R1;
      r_remaining    <= '0;
      r_stop         <= 1'b0;
      r_bitcnt       <= '0;
      r_tocnt        <= '0;
      r_phase        <= '0;
      r_shift        <= '0;
      response       <= '0;
      response_valid <= 1'b0;
      data           <= '0;
      data_valid     <= 1'b0;
      block_done     <= 1'b0;
      crc_error      <= 1'b0;
      token_error    <= 1'b0;
      timeout        <= 1'b0;
      done           <= 1'b0;
    end else begin
      response_valid <= 1'b0;
      data_valid     <= 1'b0;
      block_done     <= 1'b0;
      done           <= 1'b0;
      if (stop && (r_state != RxIdle)) r_stop <= 1'b1;

      case (r_state)
        RxIdle: begin
          if (start && !done) begin
            r_kind      <= sd_rx_kind_t'(response_type);
            r_remaining <= (block_count == '0) ? BlockCountWidth'(1) : block_count;
            r_stop      <= stop;
            crc_error   <= 1'b0;
            token_error <= 1'b0;
            timeout     <= 1'b0;
            r_tocnt     <= '0;
            r_phase     <= '0;
            r_state     <= RxWaitStart;
          end
        end

        RxWaitStart: begin
          if (sample_en) begin
            r_shift <= w_shift_next;
            r_phase <= r_phase + 3'd1;
            if (r_kind == DataBlock) begin
              if (w_token_seen) begin
                if (w_shift_next[7:0] == StartToken) begin
                  r_bitcnt <= CW'(TokenBits);
                  r_state  <= RxReceiving;
                end else begin
                  token_error    <= 1'b1;
                  response       <= {32'h0, w_shift_next[7:0]};
                  response_valid <= 1'b1;
                  done           <= 1'b1;
                  r_state        <= RxIdle;
                end
              end
            end else if (!miso) begin
              r_shift  <= '0;
              r_bitcnt <= CW'(1);
              r_state  <= RxReceiving;
            end
          end
        end

        RxReceiving: begin
          if (sample_en) begin
            r_shift  <= w_shift_next;
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_kind == DataBlock) begin
              if (w_payload_bit && (r_bitcnt[2:0] == 3'd7)) begin
                data       <= w_shift_next[7:0];
                data_valid <= 1'b1;
              end
              if (r_bitcnt == FrameLast) r_state <= RxCheckCrc;
            end else if (w_resp_last) begin
              response       <= w_shift_next;
              response_valid <= 1'b1;
              if (r_kind == R1b) begin
                r_tocnt <= '0;
                r_state <= RxWaitBusy;
              end else begin
                done    <= 1'b1;
                r_state <= RxIdle;
              end
            end
          end
        end

        RxCheckCrc: begin
          block_done  <= 1'b1;
          r_remaining <= r_remaining - 1'b1;
          if (w_crc_bad) crc_error <= 1'b1;
          if ((r_remaining == BlockCountWidth'(1)) || r_stop || stop || w_crc_bad || crc_error) begin
            done    <= 1'b1;
            r_state <= RxIdle;
          end else begin
            r_tocnt <= '0;
            r_phase <= '0;
            r_state <= RxWaitStart;
          end
        end

        RxWaitBusy: begin
          if (sample_en && miso) begin
            done    <= 1'b1;
            r_state <= RxIdle;
          end
        end

        default: r_state <= RxIdle;
      endcase

      // Idle-level strobes in WaitStart and busy-low strobes in WaitBusy share one counter.
      if (w_to_count) begin
        if (r_tocnt == TimeoutLast) begin
          timeout <= 1'b1;
          done    <= 1'b1;
          r_state <= RxIdle;
        end else begin
          r_tocnt <= r_tocnt + 1'b1;
        end
      end
    end
  end

endmodule
